// File: rtl/fsb8_pkg.sv
// Shared FSB8 definitions used by both the master bridge and the slave-side target.
package fsb8_pkg;

  localparam int unsigned TO_W = 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam logic [7:0] CMD_LOAD_PAE = 8'h00;

endpackage

// File: rtl/fsb8_target.sv
// FSB8 slave-side target: captures address frames, decodes a BASE/MASK window and
// turns each data beat into a req/ack local-bus access answered with rdy_n/err_n.
module fsb8_target
  import fsb8_pkg::*;
#(
  parameter bit                    PAE_ENABLE = 1'b0,
  parameter int unsigned           ADDR_WIDTH = PAE_ENABLE ? 32 : 24,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(24'h10_0000),
  parameter logic [ADDR_WIDTH-1:0] ADDR_MASK  = ADDR_WIDTH'(24'hF0_0000),
  parameter logic [TO_W-1:0]       TIMEOUT    = 8'd64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ale_n,
  input  logic                  cmd_n,
  input  logic                  cs_n,
  input  logic                  wr_n,
  input  logic                  typ,
  input  logic [7:0]            AAH8,
  input  logic [7:0]            AD_in,
  output logic [7:0]            AD_out,
  output logic                  ad_oe,
  output logic                  rdy_n,
  output logic                  err_n,
  output logic                  irq_n,
  output logic                  loc_req,
  output logic                  loc_we,
  output logic [ADDR_WIDTH-1:0] loc_addr,
  output logic [7:0]            loc_wdata,
  output logic                  loc_burst,
  input  logic [7:0]            loc_rdata,
  input  logic                  loc_ack,
  input  logic                  loc_err,
  input  logic                  irq_src
);

  // Only addr[W-1:8] is stored; the low byte arrives with each data beat.
  localparam int unsigned       HW       = ADDR_WIDTH - 8;
  localparam logic [HW-1:0]     PAE_MASK = HW'(24'hFF_0000);

  logic [1:0]            state_q, state_d;
  logic [HW-1:0]         addr_hi_q, addr_hi_d;
  logic [TO_W-1:0]       cnt_q, cnt_d;
  logic                  rdy_n_q, rdy_n_d;
  logic                  err_n_q, err_n_d;
  logic                  irq_n_q;
  logic                  ad_oe_q, ad_oe_d;
  logic [7:0]            ad_out_q, ad_out_d;
  logic                  loc_req_q, loc_req_d;
  logic                  loc_we_q, loc_we_d;
  logic [ADDR_WIDTH-1:0] loc_addr_q, loc_addr_d;
  logic [7:0]            loc_wdata_q, loc_wdata_d;
  logic                  loc_burst_q, loc_burst_d;

  logic [ADDR_WIDTH-1:0] beat_addr;
  logic                  hit;
  logic [TO_W-1:0]       cnt_inc;
  logic                  timeout;

  always_comb begin
    beat_addr = {addr_hi_q, AAH8};
    hit       = ((beat_addr ^ BASE_ADDR) & ADDR_MASK) == '0;
    cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + TO_W'(1);
    timeout   = (TIMEOUT != '0) && (cnt_inc >= TIMEOUT);
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    addr_hi_d   = addr_hi_q;
    cnt_d       = cnt_q;
    rdy_n_d     = rdy_n_q;
    err_n_d     = err_n_q;
    ad_oe_d     = ad_oe_q;
    ad_out_d    = ad_out_q;
    loc_req_d   = loc_req_q;
    loc_we_d    = loc_we_q;
    loc_addr_d  = loc_addr_q;
    loc_wdata_d = loc_wdata_q;
    loc_burst_d = loc_burst_q;

    // Frames are ignored while a local access is in flight
    if (state_q != ST_ACCESS) begin
      if (!ale_n) begin
        addr_hi_d[15:0] = {AAH8, AD_in};
      end
      if (!cmd_n && PAE_ENABLE && (AD_in == CMD_LOAD_PAE)) begin
        addr_hi_d = (addr_hi_d & ~PAE_MASK) | (HW'({AAH8, 16'h0}) & PAE_MASK);
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (!cs_n && hit) begin
          state_d     = ST_ACCESS;
          cnt_d       = '0;
          loc_addr_d  = beat_addr;
          loc_we_d    = !wr_n;
          loc_wdata_d = AD_in;
          loc_burst_d = typ;
          loc_req_d   = 1'b1;
          ad_oe_d     = wr_n;
        end
      end
      ST_ACCESS: begin
        cnt_d = cnt_inc;
        if (loc_ack) begin
          state_d   = ST_RESP;
          loc_req_d = 1'b0;
          rdy_n_d   = 1'b0;
          err_n_d   = !loc_err;
          if (!loc_we_q) begin
            ad_out_d = loc_rdata;
          end
        end else if (timeout) begin
          state_d   = ST_RESP;
          loc_req_d = 1'b0;
          rdy_n_d   = 1'b0;
          err_n_d   = 1'b0;
          ad_out_d  = 8'hFF;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        rdy_n_d = 1'b1;
        err_n_d = 1'b1;
        ad_oe_d = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_hi_q   <= '0;
      cnt_q       <= '0;
      rdy_n_q     <= 1'b1;
      err_n_q     <= 1'b1;
      irq_n_q     <= 1'b1;
      ad_oe_q     <= 1'b0;
      ad_out_q    <= 8'h00;
      loc_req_q   <= 1'b0;
      loc_we_q    <= 1'b0;
      loc_addr_q  <= '0;
      loc_wdata_q <= 8'h00;
      loc_burst_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_hi_q   <= addr_hi_d;
      cnt_q       <= cnt_d;
      rdy_n_q     <= rdy_n_d;
      err_n_q     <= err_n_d;
      irq_n_q     <= !irq_src;
      ad_oe_q     <= ad_oe_d;
      ad_out_q    <= ad_out_d;
      loc_req_q   <= loc_req_d;
      loc_we_q    <= loc_we_d;
      loc_addr_q  <= loc_addr_d;
      loc_wdata_q <= loc_wdata_d;
      loc_burst_q <= loc_burst_d;
    end
  end

  assign AD_out    = ad_out_q;
  assign ad_oe     = ad_oe_q;
  assign rdy_n     = rdy_n_q;
  assign err_n     = err_n_q;
  assign irq_n     = irq_n_q;
  assign loc_req   = loc_req_q;
  assign loc_we    = loc_we_q;
  assign loc_addr  = loc_addr_q;
  assign loc_wdata = loc_wdata_q;
  assign loc_burst = loc_burst_q;

endmodule

// File: tb/tb_fsb8_target.sv
// Scoreboard bench for fsb8_target (PAE enabled, 32-bit address, TIMEOUT=64).
module tb_fsb8_target;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ale_n = 1'b1, cmd_n = 1'b1, cs_n = 1'b1, wr_n = 1'b1, typ = 1'b0;
  logic [7:0]  AAH8 = 8'h00, AD_in = 8'h00;
  logic [7:0]  AD_out;
  logic        ad_oe, rdy_n, err_n, irq_n;
  logic        loc_req, loc_we, loc_burst;
  logic [31:0] loc_addr;
  logic [7:0]  loc_wdata;
  logic [7:0]  loc_rdata = 8'h00;
  logic        loc_ack = 1'b0, loc_err = 1'b0, irq_src = 1'b0;

  always #5 clk = ~clk;

  fsb8_target #(.PAE_ENABLE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .ale_n(ale_n), .cmd_n(cmd_n), .cs_n(cs_n),
    .wr_n(wr_n), .typ(typ), .AAH8(AAH8), .AD_in(AD_in), .AD_out(AD_out),
    .ad_oe(ad_oe), .rdy_n(rdy_n), .err_n(err_n), .irq_n(irq_n),
    .loc_req(loc_req), .loc_we(loc_we), .loc_addr(loc_addr),
    .loc_wdata(loc_wdata), .loc_burst(loc_burst), .loc_rdata(loc_rdata),
    .loc_ack(loc_ack), .loc_err(loc_err), .irq_src(irq_src)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [7:0]  wdata;
    logic        burst;
  } req_t;

  typedef struct {
    logic       err_n;
    logic       rd;
    logic [7:0] data;
  } rsp_t;

  req_t        exp_req[$];
  rsp_t        exp_rsp[$];
  logic [23:0] mdl_hi = 24'h0;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Monitor: pop expectations on each loc_req rise and each rdy_n-low sample
  logic req_prev = 1'b0;
  req_t mon_rq;
  rsp_t mon_rs;
  always @(negedge clk) begin
    if (loc_req && !req_prev) begin
      if (exp_req.size() == 0) begin
        check("unexp_req", 32'(loc_req), 32'd0);
      end else begin
        mon_rq = exp_req.pop_front();
        check("loc_addr", loc_addr, mon_rq.addr);
        check("loc_we", 32'(loc_we), 32'(mon_rq.we));
        check("loc_wdata", 32'(loc_wdata), 32'(mon_rq.wdata));
        check("loc_burst", 32'(loc_burst), 32'(mon_rq.burst));
      end
    end
    if (!rdy_n) begin
      if (exp_rsp.size() == 0) begin
        check("unexp_rdy", 32'(rdy_n), 32'd1);
      end else begin
        mon_rs = exp_rsp.pop_front();
        check("err_n", 32'(err_n), 32'(mon_rs.err_n));
        check("ad_oe", 32'(ad_oe), 32'(mon_rs.rd));
        if (mon_rs.rd) check("ad_out", 32'(AD_out), 32'(mon_rs.data));
      end
    end
    req_prev = loc_req;
  end

  task automatic ale_frame(input logic [7:0] hi, input logic [7:0] mid);
    ale_n = 1'b0; AAH8 = hi; AD_in = mid;
    @(negedge clk);
    ale_n = 1'b1; AD_in = 8'h00;
    mdl_hi[15:0] = {hi, mid};
  endtask

  task automatic cmd_frame(input logic [7:0] hi, input logic [7:0] cmd);
    cmd_n = 1'b0; AAH8 = hi; AD_in = cmd;
    @(negedge clk);
    cmd_n = 1'b1; AD_in = 8'h00;
    if (cmd == 8'h00) mdl_hi[23:16] = hi;
  endtask

  // One acknowledged beat; dly = clk from loc_req rise to the edge that samples loc_ack
  task automatic beat(input logic wr, input logic t, input logic [7:0] lo, input logic [7:0] wd,
                      input logic [7:0] rd, input logic lerr, input int dly);
    req_t rq;
    rsp_t rs;
    rq.addr = {mdl_hi, lo}; rq.we = ~wr; rq.wdata = wd; rq.burst = t;
    rs.err_n = ~lerr; rs.rd = wr; rs.data = rd;
    exp_req.push_back(rq);
    exp_rsp.push_back(rs);
    cs_n = 1'b0; wr_n = wr; typ = t; AAH8 = lo; AD_in = wd;
    @(negedge clk);
    cs_n = 1'b1; wr_n = 1'b1; typ = 1'b0; AD_in = 8'h00;
    check("req_lat", 32'(loc_req), 32'd1);
    repeat (dly - 1) @(negedge clk);
    loc_ack = 1'b1; loc_rdata = rd; loc_err = lerr;
    @(negedge clk);
    loc_ack = 1'b0; loc_err = 1'b0;
    check("req_drop", 32'(loc_req), 32'd0);
    @(negedge clk);
  endtask

  task automatic beat_timeout(input logic [7:0] lo);
    req_t rq;
    rsp_t rs;
    int   n;
    rq.addr = {mdl_hi, lo}; rq.we = 1'b0; rq.wdata = 8'h00; rq.burst = 1'b0;
    rs.err_n = 1'b0; rs.rd = 1'b1; rs.data = 8'hFF;
    exp_req.push_back(rq);
    exp_rsp.push_back(rs);
    cs_n = 1'b0; wr_n = 1'b1; typ = 1'b0; AAH8 = lo; AD_in = 8'h00;
    @(negedge clk);
    cs_n = 1'b1;
    n = 0;
    while (loc_req && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("to_cycles", 32'(n), 32'd64);
    check("to_rdy", 32'(rdy_n), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_rdy_n", 32'(rdy_n), 32'd1);
    check("rst_err_n", 32'(err_n), 32'd1);
    check("rst_irq_n", 32'(irq_n), 32'd1);
    check("rst_ad_oe", 32'(ad_oe), 32'd0);
    check("rst_ad_out", 32'(AD_out), 32'd0);
    check("rst_loc_req", 32'(loc_req), 32'd0);
    check("rst_loc_we", 32'(loc_we), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single write then single read at 0x102345
    ale_frame(8'h10, 8'h23);
    beat(1'b0, 1'b0, 8'h45, 8'hA5, 8'h00, 1'b0, 2);
    beat(1'b1, 1'b0, 8'h45, 8'h00, 8'h3C, 1'b0, 2);

    // Four-beat burst read, varying ack latency
    for (int i = 0; i < 4; i++) begin
      beat(1'b1, 1'b1, 8'(i), 8'h00, 8'hC0 + 8'(i), 1'b0, i + 1);
    end

    // Local error on a write, then on a read
    beat(1'b0, 1'b0, 8'h7E, 8'h5A, 8'h00, 1'b1, 1);
    beat(1'b1, 1'b0, 8'h7F, 8'h00, 8'h99, 1'b1, 3);

    // Window miss: no local request, no response
    ale_frame(8'h20, 8'h23);
    cs_n = 1'b0; wr_n = 1'b1; AAH8 = 8'h45;
    @(negedge clk);
    cs_n = 1'b1;
    check("miss_req", 32'(loc_req), 32'd0);
    repeat (3) @(negedge clk);
    check("miss_rdy", 32'(rdy_n), 32'd1);

    // Hit with no ack expires after TIMEOUT
    ale_frame(8'h10, 8'h23);
    beat_timeout(8'h46);

    // Extended address load, then an ignored command
    cmd_frame(8'h7F, 8'h00);
    beat(1'b1, 1'b0, 8'h45, 8'h00, 8'h11, 1'b0, 1);
    cmd_frame(8'h11, 8'h05);
    repeat (2) @(negedge clk);
    check("cmd05_rdy", 32'(rdy_n), 32'd1);
    beat(1'b0, 1'b0, 8'h12, 8'h34, 8'h00, 1'b0, 2);

    // Interrupt passes through one register stage
    check("irq_idle", 32'(irq_n), 32'd1);
    irq_src = 1'b1;
    @(posedge clk); #1;
    check("irq_set", 32'(irq_n), 32'd0);
    irq_src = 1'b0;
    @(posedge clk); #1;
    check("irq_clr", 32'(irq_n), 32'd1);
    @(negedge clk);

    // Reset while a read access is in flight
    begin
      req_t rq;
      rq.addr = {mdl_hi, 8'h50}; rq.we = 1'b0; rq.wdata = 8'h00; rq.burst = 1'b0;
      exp_req.push_back(rq);
    end
    cs_n = 1'b0; wr_n = 1'b1; AAH8 = 8'h50;
    @(negedge clk);
    cs_n = 1'b1;
    check("pre_rst_oe", 32'(ad_oe), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_loc_req", 32'(loc_req), 32'd0);
    check("arst_rdy_n", 32'(rdy_n), 32'd1);
    check("arst_ad_oe", 32'(ad_oe), 32'd0);
    @(negedge clk);
    loc_ack = 1'b1; loc_rdata = 8'hEE;
    @(negedge clk);
    loc_ack = 1'b0;
    rst_n = 1'b1;
    mdl_hi = 24'h0;
    repeat (3) @(negedge clk);
    check("post_rst_req", 32'(loc_req), 32'd0);
    check("post_rst_rdy", 32'(rdy_n), 32'd1);

    // Address register cleared by reset: a fresh frame is needed to hit again
    ale_frame(8'h1F, 8'h00);
    beat(1'b1, 1'b0, 8'hAA, 8'h00, 8'h42, 1'b0, 1);

    repeat (3) @(negedge clk);
    check("req_left", 32'(exp_req.size()), 32'd0);
    check("rsp_left", 32'(exp_rsp.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
